// File: rtl/unibus_arbiter_pkg.sv
// unibus_arbiter_pkg: shared FSM encoding, winner codes and grant decode for the Unibus arbiter.
package unibus_arbiter_pkg;

    localparam int DESKEW_DEF  = 8;
    localparam int SACKTMO_DEF = 1000;
    localparam int CW_DEF      = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    // Lower non-zero code means higher priority.
    typedef enum logic [2:0] {
        W_NONE,
        W_HLT,
        W_NPR,
        W_BR7,
        W_BR6,
        W_BR5,
        W_BR4
    } win_t;

    // One-hot {hlt, npr, br7, br6, br5, br4}
    function automatic logic [5:0] win_grant(input win_t w);
        return (w == W_NONE) ? 6'b000000 : (6'b100000 >> (3'(w) - 3'd1));
    endfunction

endpackage

// File: rtl/unibus_sync2.sv
// unibus_sync2: parameterised two-flop synchronizer, resets to all-ones (inactive for active-low lines).
module unibus_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_meta <= '1;
            r_q    <= '1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end

    assign o_q = r_q;

endmodule

// File: rtl/unibus_arbiter.sv
// unibus_arbiter: Unibus bus-grant arbiter (HLTRQ > NPR > BR7..BR4) with deskew,
// SACK hand-off and unacknowledged-grant timeout.
module unibus_arbiter
    import unibus_arbiter_pkg::*;
#(
    parameter int DESKEW  = DESKEW_DEF,
    parameter int SACKTMO = SACKTMO_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [3:0] bus_br_in_l,
    input  logic       bus_npr_in_l,
    input  logic       halt_rqst_in_l,
    input  logic       bus_sack_in_l,
    input  logic       bus_bbsy_in_l,
    input  logic       bus_init_in_l,
    input  logic [2:0] cpu_pri,
    input  logic       cpu_inst_bnd,
    output logic [3:0] bus_bg_out_h,
    output logic       bus_npg_out_h,
    output logic       halt_grant_out_h,
    output logic       arb_busy,
    output logic       sack_timeout
);

    logic [11:0]   w_sync;
    logic [3:0]    w_br;
    logic [3:0]    w_br_el;
    logic          w_npr;
    logic          w_hlt;
    logic          w_sack;
    logic          w_init;
    logic [2:0]    w_pri;
    logic          w_bnd;
    logic [5:0]    w_req;
    logic [5:0]    w_el;
    logic [5:0]    w_sel;
    logic          w_win_req;
    logic          w_win_el;
    win_t          w_win;
    win_t          w_win_nxt;
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_tmo_nxt;
    logic [5:0]    w_gnt;
    logic          w_unused_bbsy;

    state_t        r_state;
    win_t          r_win;
    logic [CW-1:0] r_cnt;
    logic          r_tmo;

    // BBSY is deliberately ignored: a new grant may overlap the current master's BBSY.
    assign w_unused_bbsy = bus_bbsy_in_l;

    unibus_sync2 #(.W(12)) u_sync (
        .i_clk   (CLOCK),
        .i_rst_n (RESET_N),
        .i_d     ({bus_br_in_l, bus_npr_in_l, halt_rqst_in_l, bus_sack_in_l,
                   bus_init_in_l, cpu_pri, cpu_inst_bnd}),
        .o_q     (w_sync)
    );

    assign w_br   = ~w_sync[11:8];
    assign w_npr  = ~w_sync[7];
    assign w_hlt  = ~w_sync[6];
    assign w_sack = ~w_sync[5];
    assign w_init = ~w_sync[4];
    assign w_pri  = w_sync[3:1];
    assign w_bnd  = w_sync[0];

    // w_br[i] is BR(i+4); it may win only above the processor priority.
    for (genvar i = 0; i < 4; i++) begin : g_el
        assign w_br_el[i] = w_bnd & w_br[i] & (4'(i + 4) > {1'b0, w_pri});
    end

    assign w_req = {w_hlt, w_npr, w_br};
    assign w_el  = {w_hlt & w_bnd, w_npr, w_br_el};

    assign w_win = w_el[5] ? W_HLT :
                   w_el[4] ? W_NPR :
                   w_el[3] ? W_BR7 :
                   w_el[2] ? W_BR6 :
                   w_el[1] ? W_BR5 :
                   w_el[0] ? W_BR4 : W_NONE;

    assign w_sel     = win_grant(r_win);
    assign w_win_req = |(w_req & w_sel);
    assign w_win_el  = |(w_el & w_sel);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_cnt_nxt   = w_cnt_inc;
        w_tmo_nxt   = 1'b0;
        if (w_init) begin
            w_state_nxt = S_IDLE;
            w_win_nxt   = W_NONE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_win != W_NONE && !w_sack) begin
                        w_state_nxt = S_SETTLE;
                        w_win_nxt   = w_win;
                    end
                end
                S_SETTLE: begin
                    if (!w_win_el) begin
                        w_state_nxt = S_IDLE;
                        w_win_nxt   = W_NONE;
                        w_cnt_nxt   = '0;
                    end else if (w_win != W_NONE && w_win < r_win) begin
                        w_win_nxt = w_win;
                        w_cnt_nxt = '0;
                    end else if (r_cnt == CW'(DESKEW - 1)) begin
                        w_state_nxt = S_GRANT;
                        w_cnt_nxt   = '0;
                    end
                end
                // Only the raw request matters here; priority/boundary changes keep the grant.
                S_GRANT: begin
                    if (w_sack) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                    end else if (!w_win_req) begin
                        w_state_nxt = S_IDLE;
                        w_win_nxt   = W_NONE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CW'(SACKTMO - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_win_nxt   = W_NONE;
                        w_cnt_nxt   = '0;
                        w_tmo_nxt   = 1'b1;
                    end
                end
                S_RELEASE: begin
                    w_cnt_nxt = '0;
                    if (!w_sack) begin
                        w_state_nxt = S_IDLE;
                        w_win_nxt   = W_NONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_win_nxt   = W_NONE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_win   <= W_NONE;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end

    assign w_gnt = (r_state == S_GRANT) ? w_sel : 6'b000000;
    assign {halt_grant_out_h, bus_npg_out_h, bus_bg_out_h} = w_gnt;
    assign arb_busy     = (r_state == S_GRANT) || (r_state == S_RELEASE);
    assign sack_timeout = r_tmo;

endmodule

// File: tb/tb_unibus_arbiter.sv
// tb_unibus_arbiter: directed scenarios plus random traffic against a rule-level reference model.
module tb_unibus_arbiter;

    localparam int DESKEW  = 8;
    localparam int SACKTMO = 1000;

    logic       CLOCK   = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] br_l    = 4'b1111;
    logic       npr_l   = 1'b1;
    logic       hlt_l   = 1'b1;
    logic       sack_l  = 1'b1;
    logic       bbsy_l  = 1'b1;
    logic       init_l  = 1'b1;
    logic [2:0] pri     = 3'd0;
    logic       bnd     = 1'b1;

    logic [3:0] bus_bg_out_h;
    logic       bus_npg_out_h;
    logic       halt_grant_out_h;
    logic       arb_busy;
    logic       sack_timeout;
    logic [5:0] w_gnt;
    logic [7:0] w_dut;

    int n_chk  = 0;
    int n_err  = 0;
    bit g_seen = 1'b0;

    always #5 CLOCK = ~CLOCK;

    unibus_arbiter dut (
        .CLOCK            (CLOCK),
        .RESET_N          (RESET_N),
        .bus_br_in_l      (br_l),
        .bus_npr_in_l     (npr_l),
        .halt_rqst_in_l   (hlt_l),
        .bus_sack_in_l    (sack_l),
        .bus_bbsy_in_l    (bbsy_l),
        .bus_init_in_l    (init_l),
        .cpu_pri          (pri),
        .cpu_inst_bnd     (bnd),
        .bus_bg_out_h     (bus_bg_out_h),
        .bus_npg_out_h    (bus_npg_out_h),
        .halt_grant_out_h (halt_grant_out_h),
        .arb_busy         (arb_busy),
        .sack_timeout     (sack_timeout)
    );

    assign w_gnt = {halt_grant_out_h, bus_npg_out_h, bus_bg_out_h};
    assign w_dut = {w_gnt, arb_busy, sack_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: requester index 0=HLT 1=NPR 2..5=BR7..BR4, seen through a 2-cycle delay line.
    logic [11:0] m_d1, m_d2;
    int          m_ph, m_who, m_age;
    bit          m_tmo;

    function automatic bit req(input logic [11:0] s, input int k);
        return (k == 0) ? !s[6] : (k == 1) ? !s[7] : !s[13-k];
    endfunction

    function automatic bit elig(input logic [11:0] s, input int k);
        return (k == 0) ? s[0] : (k == 1) ? 1'b1 : (s[0] && (9 - k) > int'(s[3:1]));
    endfunction

    function automatic int first(input logic [11:0] s);
        for (int k = 0; k < 6; k++)
            if (req(s, k) && elig(s, k)) return k;
        return -1;
    endfunction

    task automatic step(input logic [11:0] s);
        bit sack = !s[5];
        int f    = first(s);
        m_tmo = 1'b0;
        if (!s[4]) begin
            m_ph  = 0;
            m_age = 0;
        end else if (m_ph == 0) begin
            if (f >= 0 && !sack) begin
                m_ph  = 1;
                m_who = f;
                m_age = 0;
            end
        end else if (m_ph == 1) begin
            if (!(req(s, m_who) && elig(s, m_who))) m_ph = 0;
            else if (f >= 0 && f < m_who) begin
                m_who = f;
                m_age = 0;
            end else if (m_age == DESKEW - 1) begin
                m_ph  = 2;
                m_age = 0;
            end else m_age++;
        end else if (m_ph == 2) begin
            if (sack) m_ph = 3;
            else if (!req(s, m_who)) m_ph = 0;
            else if (m_age == SACKTMO - 1) begin
                m_ph  = 0;
                m_tmo = 1'b1;
            end else m_age++;
        end else if (!sack) m_ph = 0;
    endtask

    always @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            m_d1  = '1;
            m_d2  = '1;
            m_ph  = 0;
            m_who = 0;
            m_age = 0;
            m_tmo = 1'b0;
        end else begin
            step(m_d2);
            m_d2 = m_d1;
            m_d1 = {br_l, npr_l, hlt_l, sack_l, init_l, pri, bnd};
        end

    function automatic logic [7:0] model_vec();
        logic [5:0] g = (m_ph == 2) ? (6'b100000 >> m_who) : 6'b000000;
        return {g, (m_ph == 2 || m_ph == 3), m_tmo};
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("cycle", 32'(w_dut), 32'(model_vec()));
        if (w_gnt != 6'b0) g_seen = 1'b1;
    endtask

    task automatic wait_gnt();
        int c = 0;
        do begin
            tick();
            c++;
        end while (w_gnt == 6'b0 && c < 200);
        check("gnt_seen", 32'(w_gnt != 6'b0), 32'd1);
    endtask

    task automatic handshake();
        sack_l = 1'b0;
        repeat (5) tick();
        sack_l = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        int c;
        repeat (3) @(negedge CLOCK);
        check("reset", 32'(w_dut), 32'd0);
        RESET_N = 1'b1;
        repeat (3) tick();

        // NPR latency, SACK drop, release
        npr_l = 1'b0;
        c = 0;
        do begin tick(); c++; end while (!bus_npg_out_h && c < 50);
        check("npg_latency", 32'(c), 32'(DESKEW + 3));
        sack_l = 1'b0;
        npr_l  = 1'b1;
        c = 0;
        do begin tick(); c++; end while (bus_npg_out_h && c < 20);
        check("sack_drop", 32'(c), 32'd3);
        check("busy_release", 32'(arb_busy), 32'd1);
        sack_l = 1'b1;
        c = 0;
        do begin tick(); c++; end while (arb_busy && c < 20);
        check("busy_clear", 32'(c), 32'd3);

        // BR6 above priority 5, BR5 held off
        pri  = 3'd5;
        br_l = 4'b1001;
        wait_gnt();
        check("bg6_only", 32'(w_gnt), 32'h04);
        br_l[2] = 1'b1;
        handshake();
        g_seen = 1'b0;
        repeat (40) tick();
        check("br5_blocked", 32'(g_seen), 32'd0);
        pri = 3'd4;
        wait_gnt();
        check("bg5_after_pri", 32'(w_gnt), 32'h02);
        br_l = 4'b1111;
        handshake();

        // NPR beats BR7, then BR7 served
        br_l  = 4'b0111;
        npr_l = 1'b0;
        wait_gnt();
        check("npr_first", 32'(w_gnt), 32'h10);
        npr_l = 1'b1;
        handshake();
        wait_gnt();
        check("bg7_second", 32'(w_gnt), 32'h08);
        br_l = 4'b1111;
        handshake();

        // unacknowledged grant times out
        npr_l = 1'b0;
        wait_gnt();
        c = 0;
        do begin tick(); c++; end while (bus_npg_out_h && c < SACKTMO + 100);
        check("tmo_length", 32'(c), 32'(SACKTMO));
        check("tmo_pulse", 32'(sack_timeout), 32'd1);
        npr_l = 1'b1;
        tick();
        check("tmo_one_cycle", 32'(sack_timeout), 32'd0);
        repeat (10) tick();

        // BR4 withdrawn mid-settle
        pri    = 3'd0;
        g_seen = 1'b0;
        br_l   = 4'b1110;
        repeat (6) tick();
        br_l = 4'b1111;
        repeat (20) tick();
        check("br4_no_grant", 32'(g_seen), 32'd0);
        check("br4_idle", 32'(arb_busy), 32'd0);

        // async reset and bus init during grant
        npr_l = 1'b0;
        wait_gnt();
        #2 RESET_N = 1'b0;
        #1 check("async_reset", 32'(w_dut), 32'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        wait_gnt();
        init_l = 1'b0;
        c = 0;
        do begin tick(); c++; end while (w_gnt != 6'b0 && c < 20);
        check("init_drop", 32'(c), 32'd3);
        check("init_no_tmo", 32'(sack_timeout), 32'd0);
        init_l = 1'b1;
        npr_l  = 1'b1;
        repeat (10) tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 5) br_l = br_l ^ (4'b0001 << $urandom_range(3));
            if ($urandom_range(99) < 4) npr_l = ~npr_l;
            if ($urandom_range(99) < 2) hlt_l = ~hlt_l;
            if ($urandom_range(99) < 8) sack_l = ~sack_l;
            if (!init_l) init_l = ($urandom_range(1) == 0);
            else if ($urandom_range(999) < 5) init_l = 1'b0;
            if ($urandom_range(99) < 3) pri = 3'($urandom_range(7));
            if ($urandom_range(99) < 10) bnd = ~bnd;
            bbsy_l = 1'($urandom_range(1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
